dot_product_4n: RTL

Four-neuron similarity engine feeding the 4-input winner-take-all comparator. It streams one time-surface sample per accepted cycle, together with the matching weight of each of four neurons. It multiply-accumulates the four dot products over `p_syn` synapses. It then presents the four saturated sums, held stable, as the comparator's a/b/c/d operands with a one-cycle valid strobe.

---
 rtl/dot_product_4n.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dot_product_4n.sv
//----------------------------------------------------------------------------
// Module      : dot_product_4n
// Description : Four-neuron streaming MAC producing saturated dot products
//               as held operands for the 4-input winner-take-all comparator.
// Revision    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module dot_product_4n #(
  parameter int p_in_width = 8,
  parameter int p_w_width  = 8,
  parameter int p_syn      = 16,
  parameter int p_width    = 19
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_valid,
  input  logic [p_in_width-1:0]      i_ts,
  input  logic [p_w_width-1:0]       i_w_a,
  input  logic [p_w_width-1:0]       i_w_b,
  input  logic [p_w_width-1:0]       i_w_c,
  input  logic [p_w_width-1:0]       i_w_d,
  output logic                       o_ready,
  output logic [$clog2(p_syn)-1:0]   o_syn_idx,
  output logic [p_width-1:0]         o_a,
  output logic [p_width-1:0]         o_b,
  output logic [p_width-1:0]         o_c,
  output logic [p_width-1:0]         o_d,
  output logic                       o_valid,
  output logic                       o_busy
);

  localparam int c_idx_w  = $clog2(p_syn);
  localparam int c_prod_w = p_in_width + p_w_width;
  localparam int c_sum_w  = ((c_prod_w > p_width) ? c_prod_w : p_width) + 1;
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(p_syn - 1);
  localparam logic [p_width-1:0] c_max  = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                          r_state;
  logic [c_idx_w-1:0]              r_cnt;
  logic [3:0][p_width-1:0]         r_acc;
  logic [3:0][p_width-1:0]         r_res;
  logic                            r_valid;
  logic [3:0][p_width-1:0]         w_acc_nxt;
  logic [3:0][p_w_width-1:0]       w_w;
  logic                            w_accept;
  logic                            w_last;
  logic                            w_restart;

  assign w_w = {i_w_d, i_w_c, i_w_b, i_w_a};

  // Completion wins over a simultaneous restart request.
  assign w_accept  = (r_state == ACC) & i_valid;
  assign w_last    = w_accept & (r_cnt == c_last);
  assign w_restart = (r_state == ACC) & i_start & ~w_last;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_mac
      logic [c_prod_w-1:0] w_prod;
      logic [c_sum_w-1:0]  w_sum;

      assign w_prod       = i_ts * w_w[g];
      assign w_sum        = c_sum_w'(r_acc[g]) + c_sum_w'(w_prod);
      assign w_acc_nxt[g] = (w_sum > c_sum_w'(c_max)) ? c_max : w_sum[p_width-1:0];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= ACC;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        ACC: begin
          if (w_last) begin
            r_res   <= w_acc_nxt;
            r_valid <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_restart) begin
            r_cnt <= '0;
            r_acc <= '0;
          end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + c_idx_w'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_ready   = (r_state == ACC);
  assign o_busy    = (r_state == ACC);
  assign o_syn_idx = r_cnt;
  assign o_valid   = r_valid;
  assign o_a       = r_res[0];
  assign o_b       = r_res[1];
  assign o_c       = r_res[2];
  assign o_d       = r_res[3];

endmodule

`default_nettype wire
